// File: rtl/bp_ctrl_if.sv
// bp_ctrl_if: bundle of the fetcher, predictor-table and ROB signals seen by
// bp_ctrl. Signal names keep the original bp_ctrl port names.
//   slave  : bp_ctrl side (in_* inputs, out_* outputs)
//   master : environment side (drives in_*, observes out_*)
//   fetcher : in_fetcher_pc, in_fetcher_br_valid, out_fetcher_jump_res, out_fetcher_tag
//   table   : out_bp_tag, in_bp_jump_res, out_bp_upd_valid/tag/res
//   ROB     : in_rob_br_valid, in_rob_tag, in_rob_jump_res, in_rob_mispredict
//   stats   : out_br_cnt, out_mis_cnt
interface bp_ctrl_if #(
  parameter int unsigned GHR_W = 8
);
  logic [31:0]      in_fetcher_pc;
  logic             in_fetcher_br_valid;
  logic             out_fetcher_jump_res;
  logic [GHR_W-1:0] out_fetcher_tag;
  logic [GHR_W-1:0] out_bp_tag;
  logic             in_bp_jump_res;
  logic             in_rob_br_valid;
  logic [GHR_W-1:0] in_rob_tag;
  logic             in_rob_jump_res;
  logic             in_rob_mispredict;
  logic             out_bp_upd_valid;
  logic [GHR_W-1:0] out_bp_upd_tag;
  logic             out_bp_upd_res;
  logic [31:0]      out_br_cnt;
  logic [31:0]      out_mis_cnt;

  modport slave (
    input  in_fetcher_pc, in_fetcher_br_valid, in_bp_jump_res,
           in_rob_br_valid, in_rob_tag, in_rob_jump_res, in_rob_mispredict,
    output out_fetcher_jump_res, out_fetcher_tag, out_bp_tag,
           out_bp_upd_valid, out_bp_upd_tag, out_bp_upd_res,
           out_br_cnt, out_mis_cnt
  );

  modport master (
    output in_fetcher_pc, in_fetcher_br_valid, in_bp_jump_res,
           in_rob_br_valid, in_rob_tag, in_rob_jump_res, in_rob_mispredict,
    input  out_fetcher_jump_res, out_fetcher_tag, out_bp_tag,
           out_bp_upd_valid, out_bp_upd_tag, out_bp_upd_res,
           out_br_cnt, out_mis_cnt
  );
endinterface

// File: rtl/bp_ctrl.sv
// bp_ctrl: branch-predictor index/update controller.
// Forms the predictor-table index from the fetch PC (gshare: XOR with a
// speculative global history), passes the table prediction back to the
// fetcher, registers ROB commit outcomes into a one-stage table update and
// counts committed branches and mispredicts.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   rdy  - global ready; all state holds while low
//   bus  - bp_ctrl_if.slave (fetcher, table and ROB signals)
// Configuration macro: BP_GSHARE_EN
//   defined   - index = pc[9:2] ^ spec_ghr, speculative/committed history live
//   undefined - index = pc[9:2] (bimodal), no history registers
module bp_ctrl #(
  parameter int unsigned GHR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  bp_ctrl_if.slave    bus
);

  logic             recover;
  logic [GHR_W-1:0] pc_idx;
  logic [GHR_W-1:0] tag;

  // Mispredict flag is only meaningful alongside a committing branch.
  assign recover = bus.in_rob_br_valid & bus.in_rob_mispredict;
  assign pc_idx  = bus.in_fetcher_pc[GHR_W+1:2];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] commit_ghr;

  // On recovery the speculative history is rebuilt from the committed copy
  // plus the resolving branch, discarding any fetch shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else if (rdy) begin
      if (recover)
        spec_ghr <= {commit_ghr[GHR_W-2:0], bus.in_rob_jump_res};
      else if (bus.in_fetcher_br_valid)
        spec_ghr <= {spec_ghr[GHR_W-2:0], bus.in_bp_jump_res};
      if (bus.in_rob_br_valid)
        commit_ghr <= {commit_ghr[GHR_W-2:0], bus.in_rob_jump_res};
    end
  end

  assign tag = pc_idx ^ spec_ghr;

  logic unused_pc;
  assign unused_pc = ^{bus.in_fetcher_pc[31:GHR_W+2], bus.in_fetcher_pc[1:0]};
`else
  assign tag = pc_idx;

  logic unused_pc;
  assign unused_pc = ^{bus.in_fetcher_pc[31:GHR_W+2], bus.in_fetcher_pc[1:0],
                       bus.in_fetcher_br_valid};
`endif

  assign bus.out_bp_tag           = tag;
  assign bus.out_fetcher_tag      = tag;
  assign bus.out_fetcher_jump_res = bus.in_bp_jump_res;

  // Update strobe is re-captured every ready cycle, so with rdy low it is
  // held and the table sees it exactly once when rdy returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_bp_upd_valid <= 1'b0;
      bus.out_bp_upd_tag   <= '0;
      bus.out_bp_upd_res   <= 1'b0;
      bus.out_br_cnt       <= '0;
      bus.out_mis_cnt      <= '0;
    end else if (rdy) begin
      bus.out_bp_upd_valid <= bus.in_rob_br_valid;
      bus.out_bp_upd_tag   <= bus.in_rob_tag;
      bus.out_bp_upd_res   <= bus.in_rob_jump_res;
      if (bus.in_rob_br_valid)
        bus.out_br_cnt <= bus.out_br_cnt + 32'd1;
      if (recover)
        bus.out_mis_cnt <= bus.out_mis_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bp_ctrl.sv
// tb_bp_ctrl: self-checking bench for bp_ctrl. Directed scenarios followed by
// randomized traffic, all checked against a behavioural model of history,
// update register and counters. Follows the BP_GSHARE_EN setting of the build.
module tb_bp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;

  bp_ctrl_if #(.GHR_W(8)) bus ();

  bp_ctrl #(.GHR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural model state
  int unsigned m_spec   = 0;
  int unsigned m_commit = 0;
  bit          m_uv     = 0;
  int unsigned m_ut     = 0;
  bit          m_ur     = 0;
  logic [31:0] m_br     = '0;
  logic [31:0] m_mis    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_index(input logic [31:0] pc);
    int unsigned idx;
    idx = (int'(pc) >> 2) % 256;
`ifdef BP_GSHARE_EN
    idx = idx ^ m_spec;
`endif
    return idx;
  endfunction

  // One cycle: called at a negedge; drives inputs, checks the combinational
  // lookup, advances the model across the posedge and checks registered state.
  task automatic step(input bit r, input bit rd, input logic [31:0] pc,
                      input bit fv, input bit jr, input bit rv,
                      input logic [7:0] rt, input bit rres, input bit mis);
    bit rec;
    rst = r;  rdy = rd;
    bus.in_fetcher_pc       = pc;
    bus.in_fetcher_br_valid = fv;
    bus.in_bp_jump_res      = jr;
    bus.in_rob_br_valid     = rv;
    bus.in_rob_tag          = rt;
    bus.in_rob_jump_res     = rres;
    bus.in_rob_mispredict   = mis;
    #1;
    check("bp_tag",      32'(bus.out_bp_tag),           32'(exp_index(pc)));
    check("fetcher_tag", 32'(bus.out_fetcher_tag),      32'(exp_index(pc)));
    check("fetch_jr",    32'(bus.out_fetcher_jump_res), 32'(jr));

    if (r) begin
      m_spec = 0; m_commit = 0; m_uv = 0; m_ut = 0; m_ur = 0; m_br = '0; m_mis = '0;
    end else if (rd) begin
      rec = rv && mis;
      if (rec)     m_spec = (m_commit * 2 + rres) % 256;
      else if (fv) m_spec = (m_spec * 2 + jr) % 256;
      if (rv)      m_commit = (m_commit * 2 + rres) % 256;
      m_uv = rv; m_ut = rt; m_ur = rres;
      if (rv)  m_br  = m_br + 1;
      if (rec) m_mis = m_mis + 1;
    end

    @(posedge clk);
    @(negedge clk);
    check("upd_valid", 32'(bus.out_bp_upd_valid), 32'(m_uv));
    check("upd_tag",   32'(bus.out_bp_upd_tag),   32'(m_ut));
    check("upd_res",   32'(bus.out_bp_upd_res),   32'(m_ur));
    check("br_cnt",    bus.out_br_cnt,            m_br);
    check("mis_cnt",   bus.out_mis_cnt,           m_mis);
  endtask

  task automatic idle(input logic [31:0] pc);
    step(0, 1, pc, 0, 0, 0, 8'h00, 0, 0);
  endtask

  initial begin
    bus.in_fetcher_pc       = '0;
    bus.in_fetcher_br_valid = 1'b0;
    bus.in_bp_jump_res      = 1'b0;
    bus.in_rob_br_valid     = 1'b0;
    bus.in_rob_tag          = '0;
    bus.in_rob_jump_res     = 1'b0;
    bus.in_rob_mispredict   = 1'b0;
    @(negedge clk);

    // Reset, then lookup with empty history
    step(1, 1, 32'h0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0000_0010, 0, 0, 0, 8'h00, 0, 0);
    rst = 1'b0;
    #1;
    check("reset_tag", 32'(bus.out_bp_tag), 32'h04);
    @(negedge clk);

    // Three fetch branches 1,0,1 then lookup at pc 0x10
    step(0, 1, 32'h0000_1000, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0000_2004, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0000_3008, 1, 1, 0, 8'h00, 0, 0);
    idle(32'h0000_0010);
`ifdef BP_GSHARE_EN
    check("ghr_tag", 32'(exp_index(32'h0000_0010)), 32'h01);
`endif

    // Commit tag 0x3C res 1
    step(0, 1, 32'h0, 0, 0, 1, 8'h3C, 1, 0);
    idle(32'h0);

    // Recovery: commit_ghr -> 0x02, spec_ghr -> 0x2B, then mispredict + fetch
    step(1, 1, 32'h0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 0, 0, 1, 8'h11, 1, 0);
    step(0, 1, 32'h0, 0, 0, 1, 8'h22, 0, 0);
    step(0, 1, 32'h0, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 32'h0, 1, 0, 1, 8'h55, 1, 1);
    idle(32'h0000_0010);
    check("mis_after_rec", bus.out_mis_cnt, 32'd1);

    // Commit followed by three rdy-low cycles (ROB activity ignored)
    step(0, 1, 32'h0, 0, 0, 1, 8'hA7, 1, 0);
    step(0, 0, 32'h40, 1, 1, 1, 8'h12, 0, 1);
    step(0, 0, 32'h80, 1, 0, 1, 8'h34, 1, 0);
    step(0, 0, 32'hC0, 0, 1, 1, 8'h56, 0, 1);
    check("held_strobe", 32'(bus.out_bp_upd_valid), 32'd1);
    idle(32'h0);

    // Counter wrap from 0xFFFF_FFFF
    force bus.out_br_cnt = 32'hFFFF_FFFF;
    #1;
    release bus.out_br_cnt;
    m_br = 32'hFFFF_FFFF;
    step(0, 1, 32'h0, 0, 0, 1, 8'h01, 0, 0);
    check("br_wrap", bus.out_br_cnt, 32'd0);

    // Mid-stream reset drops a pending commit
    step(0, 1, 32'h0, 0, 0, 1, 8'h99, 1, 1);
    step(1, 1, 32'h0, 1, 1, 1, 8'h77, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), $urandom,
           1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_ctrl.md
# bp_ctrl

Branch-predictor index and update controller between the fetcher, the ROB and the 256-entry 2-bit predictor table. Forms the table index for each fetched conditional branch from the PC and a speculative 8-bit global history register (gshare), returns the prediction to the fetcher, and keeps a committed history copy for recovery. Commit-time updates go to the table through a one-stage register, and the block counts committed branches and mispredicts.

## Interface
Parameters:
- GHR_W, 8: history width; equals the table index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all state holds.
- in_fetcher_pc  in  32  PC of the instruction being fetched.
- in_fetcher_br_valid  in  1  fetcher consumes a conditional-branch prediction this cycle.
- out_fetcher_jump_res  out  1  predicted taken.
- out_fetcher_tag  out  8  index used; the fetcher carries it to the ROB.
- out_bp_tag  out  8  lookup index to the table.
- in_bp_jump_res  in  1  table prediction (counter MSB), combinational.
- in_rob_br_valid  in  1  ROB commits a conditional branch.
- in_rob_tag  in  8  index carried with the committing branch.
- in_rob_jump_res  in  1  actual outcome.
- in_rob_mispredict  in  1  committing branch was mispredicted; the ROB flushes this cycle.
- out_bp_upd_valid  out  1  table update strobe.
- out_bp_upd_tag  out  8  table update index.
- out_bp_upd_res  out  1  table update direction.
- out_br_cnt  out  32  committed branch count.
- out_mis_cnt  out  32  mispredict count.

## Operation
- Index (combinational): tag = in_fetcher_pc[9:2] ^ spec_ghr. Drives out_bp_tag and out_fetcher_tag.
- out_fetcher_jump_res = in_bp_jump_res, combinational.
- Speculative history: on rdy & in_fetcher_br_valid & !recover, spec_ghr <= {spec_ghr[6:0], in_bp_jump_res}.
- Committed history: on rdy & in_rob_br_valid, commit_ghr <= {commit_ghr[6:0], in_rob_jump_res}.
- Recovery: recover = in_rob_br_valid & in_rob_mispredict. When set, spec_ghr <= {commit_ghr[6:0], in_rob_jump_res}. Recovery overrides any fetch shift in the same cycle.
- in_rob_mispredict without in_rob_br_valid is ignored.
- Update register: every rdy cycle, out_bp_upd_valid/tag/res <= in_rob_br_valid/in_rob_tag/in_rob_jump_res.
- Counters: on rdy & in_rob_br_valid, out_br_cnt += 1. On recover, out_mis_cnt += 1. Both wrap at 2^32.
- rdy low: every register holds. The update strobe stays asserted, and the table applies it exactly once when rdy returns.

## Timing
- Reset values: spec_ghr = 0, commit_ghr = 0, out_bp_upd_valid = 0, out_bp_upd_tag = 0, out_bp_upd_res = 0, both counters = 0.
- Lookup and prediction have zero latency (same cycle as the PC).
- Speculative history is visible to the fetch that follows in_fetcher_br_valid by one cycle.
- Table update has one-cycle latency after the commit cycle; throughput is one update per cycle.
- Recovery: the first post-flush fetch, one cycle after recover, uses the restored spec_ghr.
- rst asserted mid-stream: all state clears on that edge, and any pending update strobe is dropped.

## Configuration
- BP_GSHARE_EN defined: index = pc[9:2] ^ spec_ghr, and both history registers are live.
- BP_GSHARE_EN undefined: index = pc[9:2] (bimodal), and the history registers are not implemented. The update path and counters are unchanged. With rdy high and the same sequences, out_bp_upd_* and the counters match the defined build.

## Test plan
- Reset, then pc = 0x0000_0010 with spec_ghr = 0 -> out_bp_tag = 0x04. Next cycle: out_bp_upd_valid = 0 and both counters = 0.
- GSHARE: three fetch branches with in_bp_jump_res = 1,0,1 -> spec_ghr = 0x05. Then pc = 0x0000_0010 -> tag = 0x01.
- Commit of tag 0x3C, res 1 -> the next cycle shows out_bp_upd_valid = 1, tag = 0x3C, res = 1, and out_br_cnt = 1.
- commit_ghr = 0x02 and spec_ghr = 0x2B; mispredict commit with res 1 plus a simultaneous fetch branch -> spec_ghr = 0x05 and out_mis_cnt = 1. The fetch shift is discarded.
- Commit with rdy low for 3 cycles following -> update strobe held and counters unchanged. Once rdy returns, one update is applied.
- Counter preloaded near wrap (out_br_cnt = 0xFFFF_FFFF) plus one commit -> 0. BP_GSHARE_EN undefined with pc = 0x0000_0010 -> tag = 0x04 regardless of branch history.
